// File: rtl/data_memory_stage.sv
// Memory pipeline stage: owns the data RAM, writes stores in one cycle, and
// services loads with READ_WAIT wait states while stalling upstream.
module data_memory_stage #(
  parameter int ADDR_W    = 14,
  parameter int READ_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instructionMemory,
  input  logic [ADDR_W-1:0] dataAddress,
  input  logic [31:0]       dataIn,
  input  logic [31:0]       ALUIn,
  output logic              memStall,
  output logic [31:0]       instructionWriteBack,
  output logic [31:0]       wbData,
  output logic              loadValid
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [4:0] OPC_LOAD  = 5'h01;
  localparam logic [4:0] OPC_STORE = 5'h02;
  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

  state_t            state, state_next;
  logic [3:0]        counter;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       instr_q;
  logic [31:0]       mem [2**ADDR_W];

  logic [4:0] opc;
  logic       is_load, is_store;

  always_comb begin
    opc      = instructionMemory[12:8];
    is_load  = (opc == OPC_LOAD);
    is_store = (opc == OPC_STORE);
  end

  // The final WAIT cycle (counter == 0) releases the stall so upstream
  // advances exactly once per LOAD.
  always_comb begin
    memStall = ((state == S_IDLE) && is_load) ||
               ((state == S_WAIT) && (counter != '0));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (is_load) state_next = S_WAIT;
      S_WAIT:  if (counter == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // RAM contents survive reset; writes only happen from IDLE.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_IDLE) && is_store) begin
      mem[dataAddress] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      counter              <= '0;
      instructionWriteBack <= '0;
      wbData               <= '0;
      loadValid            <= 1'b0;
      instr_q              <= '0;
    end else begin
      state     <= state_next;
      loadValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (is_load) begin
            addr_q               <= dataAddress;
            instr_q              <= instructionMemory;
            counter              <= WAIT_INIT;
            instructionWriteBack <= '0;
          end else begin
            instructionWriteBack <= instructionMemory;
            wbData               <= ALUIn;
          end
        end
        S_WAIT: begin
          if (counter != '0) begin
            counter              <= counter - 4'd1;
            instructionWriteBack <= '0;
          end else begin
            wbData               <= mem[addr_q];
            instructionWriteBack <= instr_q;
            loadValid            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage (ADDR_W=14, READ_WAIT=2) with
// hand-computed expectations.
module tb_data_memory_stage;

  localparam int ADDR_W    = 14;
  localparam int READ_WAIT = 2;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;
  localparam logic [31:0] LD     = 32'h0000_0130;
  localparam logic [31:0] ST     = 32'h0000_0200;
  localparam logic [31:0] ALU    = 32'h0000_0540;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       instructionMemory;
  logic [ADDR_W-1:0] dataAddress;
  logic [31:0]       dataIn;
  logic [31:0]       ALUIn;
  logic              memStall;
  logic [31:0]       instructionWriteBack;
  logic [31:0]       wbData;
  logic              loadValid;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_stage #(.ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instructionMemory    (instructionMemory),
    .dataAddress          (dataAddress),
    .dataIn               (dataIn),
    .ALUIn                (ALUIn),
    .memStall             (memStall),
    .instructionWriteBack (instructionWriteBack),
    .wbData               (wbData),
    .loadValid            (loadValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] din, input logic [31:0] alu);
    instructionMemory = instr;
    dataAddress       = addr;
    dataIn            = din;
    ALUIn             = alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [ADDR_W-1:0] addr, input logic [31:0] din, input string tag);
    drive(ST, addr, din, 32'hA5A5_0000 | 32'(addr));
    #1 check({tag, "_stall"}, 32'(memStall), 32'd0);
    tick();
    check({tag, "_iwb"}, instructionWriteBack, ST);
    check({tag, "_wb"}, wbData, 32'hA5A5_0000 | 32'(addr));
    check({tag, "_lv"}, 32'(loadValid), 32'd0);
  endtask

  // LOAD accepted in cycle T; during WAIT cycles the given instruction is
  // presented instead of the held LOAD. Ends in T+READ_WAIT+1 with a bubble driven.
  task automatic do_load(input logic [ADDR_W-1:0] addr, input logic [31:0] exp,
                         input logic [31:0] wi, input logic [ADDR_W-1:0] wa,
                         input logic [31:0] wd, input string tag);
    drive(LD, addr, 32'h0, 32'hFFFF_FFFF);
    #1 check({tag, "_stallT"}, 32'(memStall), 32'd1);
    tick();
    drive(wi, wa, wd, 32'h7777_7777);
    for (int k = 1; k < READ_WAIT; k++) begin
      check({tag, "_stall_w"}, 32'(memStall), 32'd1);
      check({tag, "_iwb_w"}, instructionWriteBack, BUBBLE);
      check({tag, "_lv_w"}, 32'(loadValid), 32'd0);
      tick();
    end
    check({tag, "_stall_last"}, 32'(memStall), 32'd0);
    check({tag, "_iwb_last"}, instructionWriteBack, BUBBLE);
    check({tag, "_lv_last"}, 32'(loadValid), 32'd0);
    tick();
    drive(BUBBLE, '0, 32'h0, 32'h0);
    check({tag, "_lv"}, 32'(loadValid), 32'd1);
    check({tag, "_data"}, wbData, exp);
    check({tag, "_iwb"}, instructionWriteBack, LD);
  endtask

  initial begin
    rst = 1'b1;
    drive(BUBBLE, '0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_iwb", instructionWriteBack, 32'h0);
    check("rst_wb", wbData, 32'h0);
    check("rst_lv", 32'(loadValid), 32'd0);
    check("rst_stall", 32'(memStall), 32'd0);
    rst = 1'b0;

    // Store then load
    do_store(14'h0010, 32'hDEAD_BEEF, "st10");
    do_load(14'h0010, 32'hDEAD_BEEF, LD, 14'h0010, 32'h0, "ld10");
    tick();
    check("ld10_pulse_end", 32'(loadValid), 32'd0);

    // Pass-through ALU op and bubble
    drive(ALU, 14'h0123, 32'h5555_5555, 32'h1234_5678);
    #1 check("alu_stall", 32'(memStall), 32'd0);
    tick();
    check("alu_iwb", instructionWriteBack, ALU);
    check("alu_wb", wbData, 32'h1234_5678);
    check("alu_lv", 32'(loadValid), 32'd0);
    drive(BUBBLE, '0, 32'h0, 32'h0000_00AB);
    #1 check("bub_stall", 32'(memStall), 32'd0);
    tick();
    check("bub_iwb", instructionWriteBack, BUBBLE);
    check("bub_wb", wbData, 32'h0000_00AB);

    // STORE presented during WAIT must not write
    do_store(14'h0020, 32'h0, "st20");
    do_load(14'h0010, 32'hDEAD_BEEF, ST, 14'h0020, 32'hCAFE_F00D, "ldwait");
    do_load(14'h0020, 32'h0, LD, 14'h0020, 32'h0, "ld20");

    // Back-to-back loads of top and bottom addresses
    do_store(14'h3FFF, 32'h1111_2222, "sttop");
    do_store(14'h0000, 32'h3333_4444, "stbot");
    do_load(14'h3FFF, 32'h1111_2222, LD, 14'h3FFF, 32'h0, "ldtop");
    do_load(14'h0000, 32'h3333_4444, LD, 14'h0000, 32'h0, "ldbot");
    tick();
    check("ldbot_pulse_end", 32'(loadValid), 32'd0);

    // Reset during the first WAIT cycle aborts the read
    drive(LD, 14'h0010, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    drive(BUBBLE, '0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    check("rstw_stall", 32'(memStall), 32'd0);
    check("rstw_lv", 32'(loadValid), 32'd0);
    check("rstw_iwb", instructionWriteBack, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstw_nopulse", 32'(loadValid), 32'd0);
    end
    do_load(14'h0010, 32'hDEAD_BEEF, LD, 14'h0010, 32'h0, "ldafter");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
